// File: rtl/onehot_req_arbiter.sv
// ----------------------------------------------------------------------------
// onehot_req_arbiter
//
// Front-end for the 8-to-3 encoder stage. Pulsed requests on eight lines are
// captured into sticky pending flags. One pending line at a time is granted
// as a one-hot vector. The grant is held under a valid/ready handshake until
// the consumer takes it.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req_in       in   [0:7] request pulses, bit i sets pending line i
//   clr_all      in   synchronous flush; wins over every other event
//   grant        out  [0:7] one-hot winner, grant[i] maps to encoder code i
//   grant_valid  out  grant holds a valid one-hot value
//   grant_ready  in   consumer accepts the grant this cycle
//   pending      out  [0:7] registered sticky request flags
//   overflow     out  sticky: a request hit a line that was already pending
//
// Build option
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                   no round-robin pointer
//                      undefined -> round-robin starting at ptr (default)
//
// Only N_REQ = 8 is supported. The 3-bit pointer and the encoder both
// assume eight lines.
// ----------------------------------------------------------------------------
module onehot_req_arbiter #(
   parameter int N_REQ = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [0:N_REQ-1] req_in,
   input  logic             clr_all,
   output logic [0:N_REQ-1] grant,
   output logic             grant_valid,
   input  logic             grant_ready,
   output logic [0:N_REQ-1] pending,
   output logic             overflow
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           state_p0, state_nxt;
   logic [0:N_REQ-1] grant_p0, grant_nxt;
   logic [0:N_REQ-1] pending_p0, pending_nxt;
   logic             ovf_p0, ovf_nxt;
   logic [0:N_REQ-1] winner;
   logic [0:N_REQ-1] clear_mask;
   logic             accept;

`ifndef ARB_FIXED_PRIO_EN
   logic [2:0]       ptr_p0, ptr_nxt;
`endif

   // Index of the set bit in a one-hot vector. The result is only meaningful
   // when exactly one bit is set. Callers only use it on a held grant.
   function automatic logic [2:0] onehot_to_idx(input logic [0:7] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

`ifndef ARB_FIXED_PRIO_EN
   // First set bit scanning ptr, ptr+1, ... 7, 0, ... ptr-1. The 3-bit index
   // sum wraps naturally at 8.
   function automatic logic [0:7] pick_rr(input logic [0:7] pend,
                                          input logic [2:0] start);
      logic [0:7] w;
      logic       found;
      logic [2:0] idx;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = start + 3'(i);
         if (!found && pend[idx]) begin
            w[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return w;
   endfunction
`else
   // Lowest index wins; line 0 has the highest priority.
   function automatic logic [0:7] pick_fixed(input logic [0:7] pend);
      logic [0:7] w;
      logic       found;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!found && pend[i]) begin
            w[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return w;
   endfunction
`endif

`ifndef ARB_FIXED_PRIO_EN
   assign winner = pick_rr(pending_p0, ptr_p0);
`else
   assign winner = pick_fixed(pending_p0);
`endif

   // --- next-state / datapath decode ---------------------------------------
   always_comb begin
      accept      = (state_p0 == S_GRANT) && grant_ready;
      clear_mask  = accept ? grant_p0 : '0;

      state_nxt   = state_p0;
      grant_nxt   = grant_p0;
      // Set wins over clear: the accepted line stays pending if it is
      // re-requested in the same cycle, and that is not an overflow.
      pending_nxt = (pending_p0 & ~clear_mask) | req_in;
      ovf_nxt     = ovf_p0 | (|(req_in & pending_p0 & ~clear_mask));
`ifndef ARB_FIXED_PRIO_EN
      ptr_nxt     = ptr_p0;
`endif

      if (clr_all) begin
         // The flush discards same-cycle requests and drops any accept.
         state_nxt   = S_IDLE;
         grant_nxt   = '0;
         pending_nxt = '0;
         ovf_nxt     = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_nxt     = 3'd0;
`endif
      end else begin
         case (state_p0)
            S_IDLE: begin
               // Selection uses the registered flags, so a request needs
               // one cycle to become pending and a second one to be granted.
               if (|pending_p0) begin
                  grant_nxt = winner;
                  state_nxt = S_GRANT;
               end
            end
            S_GRANT: begin
               // The grant is frozen until it is accepted.
               if (grant_ready) begin
                  grant_nxt = '0;
                  state_nxt = S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
                  ptr_nxt   = onehot_to_idx(grant_p0) + 3'd1;
`endif
               end
            end
            default: begin
               state_nxt = S_IDLE;
               grant_nxt = '0;
            end
         endcase
      end
   end

   // --- state registers ----------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0   <= S_IDLE;
         grant_p0   <= '0;
         pending_p0 <= '0;
         ovf_p0     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_p0     <= 3'd0;
`endif
      end else begin
         state_p0   <= state_nxt;
         grant_p0   <= grant_nxt;
         pending_p0 <= pending_nxt;
         ovf_p0     <= ovf_nxt;
`ifndef ARB_FIXED_PRIO_EN
         ptr_p0     <= ptr_nxt;
`endif
      end
   end

   assign grant       = grant_p0;
   assign grant_valid = (state_p0 == S_GRANT);
   assign pending     = pending_p0;
   assign overflow    = ovf_p0;

   // The encoder relies on grant never being multi-hot.
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant));

   // A valid grant cannot be accepted as empty.
   a_valid_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
      grant_valid |-> (grant != '0));

   // A grant that is not accepted and not flushed holds its value.
   a_grant_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (grant_valid && !grant_ready && !clr_all) |=> $stable(grant));

endmodule

// File: tb/tb_onehot_req_arbiter.sv
module tb_onehot_req_arbiter;

   logic       clk;
   logic       rst_n;
   logic [0:7] req_in;
   logic       clr_all;
   logic [0:7] grant;
   logic       grant_valid;
   logic       grant_ready;
   logic [0:7] pending;
   logic       overflow;

   int n_checks;
   int n_fail;

   onehot_req_arbiter #(.N_REQ(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_in      (req_in),
      .clr_all     (clr_all),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_ready (grant_ready),
      .pending     (pending),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled and inputs are
   // driven 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_in      = '0;
      clr_all     = 1'b0;
      grant_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (grant !== 8'b0) begin n_fail++; $display("FAIL reset_grant: got %b want %b", grant, 8'b0); end
      n_checks++;
      if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
      n_checks++;
      if (pending !== 8'b0) begin n_fail++; $display("FAIL reset_pending: got %b want %b", pending, 8'b0); end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      grant_ready = 1'b1;
      req_in      = 8'b00100000;
      tick();
      req_in = '0;
      n_checks++;
      if (pending !== 8'b00100000) begin n_fail++; $display("FAIL single_pending: got %b want %b", pending, 8'b00100000); end
      n_checks++;
      if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency1: got %b want 0", grant_valid); end
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant !== 8'b00100000) begin
         n_fail++; $display("FAIL single_grant: got v=%b g=%b want v=1 g=%b", grant_valid, grant, 8'b00100000);
      end
      tick();
      n_checks++;
      if (pending !== 8'b0 || grant_valid !== 1'b0 || grant !== 8'b0) begin
         n_fail++; $display("FAIL single_accept: got p=%b v=%b g=%b want all zero", pending, grant_valid, grant);
      end
   endtask

   task automatic test_round_robin();
      logic [0:7] exp;
      // Flush so the pointer starts at line 0.
      clr_all = 1'b1;
      tick();
      clr_all     = 1'b0;
      grant_ready = 1'b1;
      req_in      = 8'b11111111;
      tick();
      req_in = '0;
      for (int j = 0; j < 8; j++) begin
         exp    = '0;
         exp[j] = 1'b1;
         tick();
         n_checks++;
         if (grant_valid !== 1'b1 || grant !== exp) begin
            n_fail++; $display("FAIL rr_order_%0d: got v=%b g=%b want v=1 g=%b", j, grant_valid, grant, exp);
         end
         tick();
         n_checks++;
         if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_gap_%0d: got v=%b want 0", j, grant_valid); end
      end
      n_checks++;
      if (pending !== 8'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL rr_drained: got p=%b o=%b want 0 0", pending, overflow);
      end
   endtask

   task automatic test_wrap();
      grant_ready = 1'b1;
      req_in      = 8'b00000001;
      tick();
      req_in = '0;
      tick();
      n_checks++;
      if (grant !== 8'b00000001) begin n_fail++; $display("FAIL wrap_line7: got %b want %b", grant, 8'b00000001); end
      tick();
      req_in = 8'b10000001;
      tick();
      req_in = '0;
      tick();
      n_checks++;
      if (grant !== 8'b10000000) begin n_fail++; $display("FAIL wrap_first: got %b want %b", grant, 8'b10000000); end
      tick();
      tick();
      n_checks++;
      if (grant !== 8'b00000001) begin n_fail++; $display("FAIL wrap_second: got %b want %b", grant, 8'b00000001); end
      tick();
   endtask

   task automatic test_backpressure();
      grant_ready = 1'b0;
      req_in      = 8'b00010010;
      tick();
      req_in = '0;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant !== 8'b00010000) begin
         n_fail++; $display("FAIL bp_first: got v=%b g=%b want v=1 g=%b", grant_valid, grant, 8'b00010000);
      end
      for (int c = 0; c < 5; c++) begin
         // A new request on line 7 arrives while the grant is held.
         req_in = (c == 2) ? 8'b00000001 : 8'b0;
         tick();
         n_checks++;
         if (grant_valid !== 1'b1 || grant !== 8'b00010000) begin
            n_fail++; $display("FAIL bp_hold_%0d: got v=%b g=%b want v=1 g=%b", c, grant_valid, grant, 8'b00010000);
         end
      end
      req_in      = '0;
      grant_ready = 1'b1;
      tick();
      n_checks++;
      if (grant_valid !== 1'b0 || pending !== 8'b00000011) begin
         n_fail++; $display("FAIL bp_accept: got v=%b p=%b want v=0 p=%b", grant_valid, pending, 8'b00000011);
      end
      tick();
      n_checks++;
      if (grant !== 8'b00000010) begin n_fail++; $display("FAIL bp_next: got %b want %b", grant, 8'b00000010); end
      tick();
      tick();
      n_checks++;
      if (grant !== 8'b00000001) begin n_fail++; $display("FAIL bp_last: got %b want %b", grant, 8'b00000001); end
      tick();
   endtask

   task automatic test_overflow_set_over_clear();
      clr_all = 1'b1;
      tick();
      clr_all     = 1'b0;
      grant_ready = 1'b0;
      req_in      = 8'b10000000;
      tick();
      req_in = '0;
      tick();
      n_checks++;
      if (grant !== 8'b10000000 || grant_valid !== 1'b1) begin
         n_fail++; $display("FAIL soc_grant: got v=%b g=%b want v=1 g=%b", grant_valid, grant, 8'b10000000);
      end
      // Re-request line 0 in the accept cycle.
      grant_ready = 1'b1;
      req_in      = 8'b10000000;
      tick();
      req_in      = '0;
      grant_ready = 1'b0;
      n_checks++;
      if (pending !== 8'b10000000) begin n_fail++; $display("FAIL soc_pending: got %b want %b", pending, 8'b10000000); end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL soc_no_overflow: got %b want 0", overflow); end
      tick();
      n_checks++;
      if (grant !== 8'b10000000 || grant_valid !== 1'b1) begin
         n_fail++; $display("FAIL ovf_regrant: got v=%b g=%b want v=1 g=%b", grant_valid, grant, 8'b10000000);
      end
      req_in = 8'b00000001;
      tick();
      n_checks++;
      if (overflow !== 1'b0 || pending !== 8'b10000001) begin
         n_fail++; $display("FAIL ovf_first_pulse: got o=%b p=%b want o=0 p=%b", overflow, pending, 8'b10000001);
      end
      req_in = 8'b00000001;
      tick();
      req_in = '0;
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      tick();
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_flush();
      // Grant on line 0 is still held from the previous scenario.
      n_checks++;
      if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got v=%b want 1", grant_valid); end
      clr_all     = 1'b1;
      grant_ready = 1'b1;
      req_in      = 8'b00001000;
      tick();
      clr_all     = 1'b0;
      grant_ready = 1'b0;
      req_in      = '0;
      n_checks++;
      if (grant !== 8'b0 || grant_valid !== 1'b0 || pending !== 8'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL flush_all: got g=%b v=%b p=%b o=%b want all zero", grant, grant_valid, pending, overflow);
      end
      tick();
      n_checks++;
      if (grant_valid !== 1'b0 || pending[4] !== 1'b0) begin
         n_fail++; $display("FAIL flush_after: got v=%b p=%b want v=0 p=0", grant_valid, pending);
      end
   endtask

   task automatic test_async_reset();
      grant_ready = 1'b0;
      req_in      = 8'b00000100;
      tick();
      req_in = '0;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant !== 8'b00000100) begin
         n_fail++; $display("FAIL areset_pre: got v=%b g=%b want v=1 g=%b", grant_valid, grant, 8'b00000100);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (grant_valid !== 1'b0 || grant !== 8'b0 || pending !== 8'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL areset_drop: got v=%b g=%b p=%b o=%b want all zero", grant_valid, grant, pending, overflow);
      end
      #1;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL areset_after: got v=%b want 0", grant_valid); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_overflow_set_over_clear();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
